// File: rtl/dunc16_pkg.sv
// Shared definitions for the dunc16 control path: opcodes, sequencer phases,
// datapath mux-select encodings and the per-opcode execute length.
package dunc16_pkg;

    // Instruction opcodes held in IR
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Sequencer phase
    typedef enum logic [1:0] {
        PH_FETCH   = 2'd0,
        PH_EXECUTE = 2'd1,
        PH_HALT    = 2'd2
    } phase_t;

    // MA_SEL / PC_SEL sources
    localparam logic SEL_PC   = 1'b0;
    localparam logic SEL_MD   = 1'b1;
    // MD_SEL sources
    localparam logic SEL_MEM  = 1'b0;
    localparam logic SEL_AC   = 1'b1;
    // AC_SEL sources
    localparam logic SEL_ACMD = 1'b0;
    localparam logic SEL_ALU  = 1'b1;
    // PC_SEL increment source
    localparam logic SEL_INC  = 1'b0;

    // Last execute step for an opcode; memory-touching ops take two steps
    function automatic logic [1:0] exec_last_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA, OP_ADD: return 2'd1;
            default:                return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dunc16_timing.sv
// Step counter for the dunc16 sequencer. Holds on a memory stall, returns to
// T0 on clear (clear wins over hold), and presents the step as one-hot T.
module dunc16_timing (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       hold,
    input  logic       clear,
    output logic [1:0] step,
    output logic [3:0] T
);

    logic [1:0] step_r;

    // Step register: clear to T0, freeze on stall, otherwise count up
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            step_r <= 2'd0;
        end else if (clear) begin
            step_r <= 2'd0;
        end else if (hold) begin
            step_r <= step_r;
        end else begin
            step_r <= step_r + 2'd1;
        end
    end

    // One-hot decode of the current step
    always_comb begin
        T = 4'b0000;
        case (step_r)
            2'd0:    T = 4'b0001;
            2'd1:    T = 4'b0010;
            2'd2:    T = 4'b0100;
            2'd3:    T = 4'b1000;
            default: T = 4'b0000;
        endcase
    end

    assign step = step_r;

endmodule

// File: rtl/dunc16_sequencer.sv
// Control unit for the dunc16 accumulator datapath. A phase register
// (FETCH/EXECUTE/HALT) plus the step counter fully define state; every
// enable, select and memory strobe is decoded from that state (and IR in
// EXECUTE). Memory steps stretch while MEM_READY is low.
module dunc16_sequencer
    import dunc16_pkg::*;
#(
    parameter int             OPW         = 4,
    parameter logic [OPW-1:0] HALT_OPCODE = 4'hF
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [OPW-1:0] IR_OUT,
    input  logic           MEM_READY,
    input  logic           RUN,
    output logic           FETCH,
    output logic           EXECUTE,
    output logic [3:0]     T,
    output logic           EN_MA,
    output logic           EN_MD,
    output logic           EN_AC,
    output logic           EN_PC,
    output logic           EN_IR,
    output logic           MA_SEL,
    output logic           MD_SEL,
    output logic           AC_SEL,
    output logic           PC_SEL,
    output logic           MEM_RD,
    output logic           WRITE,
    output logic           HALTED
);

    phase_t     phase_r;
    phase_t     phase_nxt_s;
    logic [1:0] step_s;
    logic [3:0] t_s;
    logic       stall_s;
    logic       clear_s;
    logic       halt_op_s;
    logic [1:0] last_step_s;
    logic       en_ma_s, en_md_s, en_ac_s, en_pc_s, en_ir_s;
    logic       mem_rd_s, write_s;

    assign halt_op_s   = (IR_OUT == HALT_OPCODE);
    assign last_step_s = halt_op_s ? 2'd0 : exec_last_step(IR_OUT);
    assign stall_s     = (mem_rd_s | write_s) & ~MEM_READY;
    // Any phase change restarts at T0; HALT keeps the counter parked at T0
    assign clear_s     = (phase_nxt_s != phase_r) | (phase_r == PH_HALT);

    dunc16_timing u_timing (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .hold    (stall_s),
        .clear   (clear_s),
        .step    (step_s),
        .T       (t_s)
    );

    // Phase register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_r <= PH_FETCH;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Next phase: leave FETCH after T3, leave EXECUTE after the opcode's last step
    always_comb begin
        phase_nxt_s = phase_r;
        case (phase_r)
            PH_FETCH: begin
                if ((step_s == 2'd3) && !stall_s) begin
                    phase_nxt_s = PH_EXECUTE;
                end else begin
                    phase_nxt_s = PH_FETCH;
                end
            end
            PH_EXECUTE: begin
                if ((step_s == 2'd0) && halt_op_s) begin
                    phase_nxt_s = PH_HALT;
                end else if ((step_s == last_step_s) && !stall_s) begin
                    phase_nxt_s = PH_FETCH;
                end else begin
                    phase_nxt_s = PH_EXECUTE;
                end
            end
            PH_HALT: begin
                if (RUN) begin
                    phase_nxt_s = PH_FETCH;
                end else begin
                    phase_nxt_s = PH_HALT;
                end
            end
            default: phase_nxt_s = PH_FETCH;
        endcase
    end

    // Control decode; data-capture enables on memory steps wait for MEM_READY
    always_comb begin
        en_ma_s  = 1'b0;
        en_md_s  = 1'b0;
        en_ac_s  = 1'b0;
        en_pc_s  = 1'b0;
        en_ir_s  = 1'b0;
        mem_rd_s = 1'b0;
        write_s  = 1'b0;
        MA_SEL   = SEL_PC;
        MD_SEL   = SEL_MEM;
        AC_SEL   = SEL_ACMD;
        PC_SEL   = SEL_INC;
        case (phase_r)
            PH_FETCH: begin
                case (step_s)
                    2'd0: en_ma_s = 1'b1;
                    2'd1: begin
                        mem_rd_s = 1'b1;
                        en_md_s  = MEM_READY;
                        en_pc_s  = MEM_READY;
                    end
                    2'd2: en_ir_s = 1'b1;
                    2'd3: begin
                        en_ma_s = 1'b1;
                        MA_SEL  = SEL_MD;
                    end
                    default: en_ma_s = 1'b0;
                endcase
            end
            PH_EXECUTE: begin
                if (halt_op_s) begin
                    en_ma_s = 1'b0;
                end else begin
                    case (IR_OUT)
                        OP_LDA, OP_ADD: begin
                            if (step_s == 2'd0) begin
                                mem_rd_s = 1'b1;
                                en_md_s  = MEM_READY;
                            end else begin
                                en_ac_s = 1'b1;
                                AC_SEL  = (IR_OUT == OP_ADD) ? SEL_ALU : SEL_ACMD;
                            end
                        end
                        OP_STA: begin
                            if (step_s == 2'd0) begin
                                en_md_s = 1'b1;
                                MD_SEL  = SEL_AC;
                            end else begin
                                write_s = 1'b1;
                            end
                        end
                        OP_JMP: begin
                            en_pc_s = 1'b1;
                            PC_SEL  = SEL_MD;
                        end
                        default: en_ma_s = 1'b0;
                    endcase
                end
            end
            default: en_ma_s = 1'b0;
        endcase
    end

    // Enables are forced low while reset is asserted, even in FETCH/T0
    assign EN_MA   = en_ma_s & RESET_N;
    assign EN_MD   = en_md_s & RESET_N;
    assign EN_AC   = en_ac_s & RESET_N;
    assign EN_PC   = en_pc_s & RESET_N;
    assign EN_IR   = en_ir_s & RESET_N;
    assign MEM_RD  = mem_rd_s;
    assign WRITE   = write_s;
    assign FETCH   = (phase_r == PH_FETCH);
    assign EXECUTE = (phase_r == PH_EXECUTE);
    assign HALTED  = (phase_r == PH_HALT);
    assign T       = (phase_r == PH_HALT) ? 4'b0000 : t_s;

endmodule

// File: tb/tb_dunc16_sequencer.sv
// Directed bench for dunc16_sequencer. Control outputs are packed into one
// vector {FETCH,EXECUTE,T,EN_MA,EN_MD,EN_AC,EN_PC,EN_IR,MEM_RD,WRITE,HALTED}
// and compared against hand-written expected words each cycle.
module tb_dunc16_sequencer;

    logic       CLK       = 1'b0;
    logic       RESET_N   = 1'b0;
    logic [3:0] IR_OUT    = 4'h0;
    logic       MEM_READY = 1'b1;
    logic       RUN       = 1'b0;
    logic       FETCH, EXECUTE, EN_MA, EN_MD, EN_AC, EN_PC, EN_IR;
    logic       MA_SEL, MD_SEL, AC_SEL, PC_SEL, MEM_RD, WRITE, HALTED;
    logic [3:0] T;
    logic [13:0] obs;
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [13:0] X_RST   = {2'b10, 4'b0001, 5'b00000, 3'b000};
    localparam logic [13:0] X_F0    = {2'b10, 4'b0001, 5'b10000, 3'b000};
    localparam logic [13:0] X_F1    = {2'b10, 4'b0010, 5'b01010, 3'b100};
    localparam logic [13:0] X_F1W   = {2'b10, 4'b0010, 5'b00000, 3'b100};
    localparam logic [13:0] X_F2    = {2'b10, 4'b0100, 5'b00001, 3'b000};
    localparam logic [13:0] X_F3    = {2'b10, 4'b1000, 5'b10000, 3'b000};
    localparam logic [13:0] X_E0NOP = {2'b01, 4'b0001, 5'b00000, 3'b000};
    localparam logic [13:0] X_E0RDW = {2'b01, 4'b0001, 5'b00000, 3'b100};
    localparam logic [13:0] X_E0RD  = {2'b01, 4'b0001, 5'b01000, 3'b100};
    localparam logic [13:0] X_E1AC  = {2'b01, 4'b0010, 5'b00100, 3'b000};
    localparam logic [13:0] X_E0STA = {2'b01, 4'b0001, 5'b01000, 3'b000};
    localparam logic [13:0] X_E1WR  = {2'b01, 4'b0010, 5'b00000, 3'b010};
    localparam logic [13:0] X_E0JMP = {2'b01, 4'b0001, 5'b00010, 3'b000};
    localparam logic [13:0] X_HALT  = {2'b00, 4'b0000, 5'b00000, 3'b001};

    dunc16_sequencer dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IR_OUT    (IR_OUT),
        .MEM_READY (MEM_READY),
        .RUN       (RUN),
        .FETCH     (FETCH),
        .EXECUTE   (EXECUTE),
        .T         (T),
        .EN_MA     (EN_MA),
        .EN_MD     (EN_MD),
        .EN_AC     (EN_AC),
        .EN_PC     (EN_PC),
        .EN_IR     (EN_IR),
        .MA_SEL    (MA_SEL),
        .MD_SEL    (MD_SEL),
        .AC_SEL    (AC_SEL),
        .PC_SEL    (PC_SEL),
        .MEM_RD    (MEM_RD),
        .WRITE     (WRITE),
        .HALTED    (HALTED)
    );

    assign obs = {FETCH, EXECUTE, T, EN_MA, EN_MD, EN_AC, EN_PC, EN_IR, MEM_RD, WRITE, HALTED};

    always #5 CLK = ~CLK;

    // Advance to 2 time units after the next rising edge
    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    // Four fetch cycles with MEM_READY high; IR holds 4'hF until T3 so a
    // sequencer that looked at IR during FETCH would misbehave
    task automatic run_fetch(input logic [3:0] op);
        for (int i = 0; i < 4; i++) begin
            MEM_READY = 1'b1;
            IR_OUT    = (i < 3) ? 4'hF : op;
            tick();
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        tick();
        tick();
        #1;
        if (obs !== X_RST) begin n_bad++; $display("FAIL reset_state: got %b expected %b", obs, X_RST); end
        n_cmp++;
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_fetch_nop;
        logic [13:0] exp_q [6];
        exp_q[0] = X_F0; exp_q[1] = X_F1; exp_q[2] = X_F2;
        exp_q[3] = X_F3; exp_q[4] = X_E0NOP; exp_q[5] = X_F0;
        IR_OUT = 4'h0;
        for (int i = 0; i < 6; i++) begin
            MEM_READY = 1'b1;
            #1;
            if (obs !== exp_q[i]) begin n_bad++; $display("FAIL nop_cycle%0d: got %b expected %b", i + 1, obs, exp_q[i]); end
            n_cmp++;
            if (i == 3) begin
                if (MA_SEL !== 1'b1) begin n_bad++; $display("FAIL fetch_t3_ma_sel: got %b expected 1", MA_SEL); end
                n_cmp++;
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_lda_wait;
        run_fetch(4'h1);
        for (int i = 0; i < 3; i++) begin
            MEM_READY = 1'b0;
            #1;
            if (obs !== X_E0RDW) begin n_bad++; $display("FAIL lda_wait%0d: got %b expected %b", i, obs, X_E0RDW); end
            n_cmp++;
            tick();
        end
        MEM_READY = 1'b1;
        #1;
        if (obs !== X_E0RD) begin n_bad++; $display("FAIL lda_ready: got %b expected %b", obs, X_E0RD); end
        n_cmp++;
        if (MD_SEL !== 1'b0) begin n_bad++; $display("FAIL lda_md_sel: got %b expected 0", MD_SEL); end
        n_cmp++;
        tick();
        #1;
        if (obs !== X_E1AC) begin n_bad++; $display("FAIL lda_t1: got %b expected %b", obs, X_E1AC); end
        n_cmp++;
        if (AC_SEL !== 1'b0) begin n_bad++; $display("FAIL lda_ac_sel: got %b expected 0", AC_SEL); end
        n_cmp++;
        tick();
        #1;
        if (obs !== X_F0) begin n_bad++; $display("FAIL lda_return: got %b expected %b", obs, X_F0); end
        n_cmp++;
    endtask

    task automatic test_sta;
        run_fetch(4'h2);
        MEM_READY = 1'b1;
        #1;
        if (obs !== X_E0STA) begin n_bad++; $display("FAIL sta_t0: got %b expected %b", obs, X_E0STA); end
        n_cmp++;
        if (MD_SEL !== 1'b1) begin n_bad++; $display("FAIL sta_md_sel: got %b expected 1", MD_SEL); end
        n_cmp++;
        tick();
        for (int i = 0; i < 3; i++) begin
            MEM_READY = (i == 2);
            #1;
            if (obs !== X_E1WR) begin n_bad++; $display("FAIL sta_write%0d: got %b expected %b", i, obs, X_E1WR); end
            n_cmp++;
            tick();
        end
        #1;
        if (obs !== X_F0) begin n_bad++; $display("FAIL sta_return: got %b expected %b", obs, X_F0); end
        n_cmp++;
    endtask

    task automatic test_jmp_add;
        run_fetch(4'h4);
        #1;
        if (obs !== X_E0JMP) begin n_bad++; $display("FAIL jmp_t0: got %b expected %b", obs, X_E0JMP); end
        n_cmp++;
        if (PC_SEL !== 1'b1) begin n_bad++; $display("FAIL jmp_pc_sel: got %b expected 1", PC_SEL); end
        n_cmp++;
        tick();
        #1;
        if (obs !== X_F0) begin n_bad++; $display("FAIL jmp_5cycle: got %b expected %b", obs, X_F0); end
        n_cmp++;
        run_fetch(4'h3);
        #1;
        if (obs !== X_E0RD) begin n_bad++; $display("FAIL add_t0: got %b expected %b", obs, X_E0RD); end
        n_cmp++;
        tick();
        #1;
        if (obs !== X_E1AC) begin n_bad++; $display("FAIL add_t1: got %b expected %b", obs, X_E1AC); end
        n_cmp++;
        if (AC_SEL !== 1'b1) begin n_bad++; $display("FAIL add_ac_sel: got %b expected 1", AC_SEL); end
        n_cmp++;
        tick();
        #1;
        if (obs !== X_F0) begin n_bad++; $display("FAIL add_return: got %b expected %b", obs, X_F0); end
        n_cmp++;
    endtask

    task automatic test_halt;
        RUN    = 1'b1;
        IR_OUT = 4'hF;
        tick();
        RUN = 1'b0;
        #1;
        if (obs !== X_F1) begin n_bad++; $display("FAIL run_in_fetch: got %b expected %b", obs, X_F1); end
        n_cmp++;
        tick();
        tick();
        tick();
        #1;
        if (obs !== X_E0NOP) begin n_bad++; $display("FAIL hlt_t0: got %b expected %b", obs, X_E0NOP); end
        n_cmp++;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            if (obs !== X_HALT) begin n_bad++; $display("FAIL halted%0d: got %b expected %b", i, obs, X_HALT); end
            n_cmp++;
            tick();
        end
        RUN = 1'b1;
        #1;
        if (obs !== X_HALT) begin n_bad++; $display("FAIL halt_run_cycle: got %b expected %b", obs, X_HALT); end
        n_cmp++;
        tick();
        RUN    = 1'b0;
        IR_OUT = 4'h0;
        #1;
        if (obs !== X_F0) begin n_bad++; $display("FAIL halt_resume: got %b expected %b", obs, X_F0); end
        n_cmp++;
    endtask

    task automatic test_reset_stall;
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        #1;
        if (obs !== X_F1W) begin n_bad++; $display("FAIL fetch_stall: got %b expected %b", obs, X_F1W); end
        n_cmp++;
        tick();
        #1;
        if (obs !== X_F1W) begin n_bad++; $display("FAIL fetch_stall_hold: got %b expected %b", obs, X_F1W); end
        n_cmp++;
        RESET_N = 1'b0;
        #1;
        if (obs !== X_RST) begin n_bad++; $display("FAIL async_reset: got %b expected %b", obs, X_RST); end
        n_cmp++;
        tick();
        RESET_N   = 1'b1;
        MEM_READY = 1'b1;
        #1;
        if (obs !== X_F0) begin n_bad++; $display("FAIL reset_restart: got %b expected %b", obs, X_F0); end
        n_cmp++;
        tick();
        #1;
        if (obs !== X_F1) begin n_bad++; $display("FAIL reset_restart_t1: got %b expected %b", obs, X_F1); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_fetch_nop();
        test_lda_wait();
        test_sta();
        test_jmp_add();
        test_halt();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/dunc16_sequencer.md
Name: dunc16_sequencer

Overview:
- Control unit for the dunc16 16-bit accumulator datapath (AC, MD, MA, PC, 4-bit IR).
- Generates the one-hot T0–T3 timing, the FETCH/EXECUTE phase and all register-load enables and mux selects.
- Inserts wait states on memory accesses and decodes LDA, STA, ADD, JMP, HLT.
- Sits between the datapath and the memory interface; drives everything the datapath loads each cycle.

Parameters:
- OPW, 4, opcode width (IR_OUT width).
- HALT_OPCODE, 4'hF, opcode that stops sequencing.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IR_OUT  in  OPW  current opcode from IR.
- MEM_READY  in  1  memory access completes this cycle when high.
- RUN  in  1  one-cycle pulse; resumes from HALTED.
- FETCH, EXECUTE  out  1 each  phase flags, mutually exclusive.
- T  out  4  one-hot step, T[0]=T0.
- EN_MA, EN_MD, EN_AC, EN_PC, EN_IR  out  1 each  register load enables.
- MA_SEL  out  1  0=PC, 1=MD[11:0].
- MD_SEL  out  1  0=memory, 1=AC.
- AC_SEL  out  1  0=MD, 1=ALU sum AC+MD.
- PC_SEL  out  1  0=PC+1, 1=MD[11:0].
- MEM_RD, WRITE  out  1 each  memory strobes, held through wait states.
- HALTED  out  1  sequencer stopped.

Behaviour:
- State:
  - phase reg: FETCH, EXECUTE or HALT.
  - 2-bit step counter.
- All outputs decode combinationally from state (and IR_OUT in EXECUTE).
- While RESET_N is low:
  - all enables, MEM_RD, WRITE and HALTED are 0;
  - state is FETCH/T0; FETCH=1, T=0001.
- Step advances by 1 each cycle except on a stall. A stall is any step with MEM_RD or WRITE high while MEM_READY=0; the step and all outputs are then held unchanged.
- FETCH sequence:
  - T0: EN_MA, MA_SEL=0.
  - T1: MEM_RD, EN_MD, MD_SEL=0, EN_PC, PC_SEL=0. EN_MD and EN_PC assert only in the cycle MEM_READY=1, so PC increments exactly once.
  - T2: EN_IR.
  - T3: EN_MA, MA_SEL=1; next cycle is EXECUTE/T0.
- EXECUTE sequence; the last listed step returns to FETCH/T0:
  - LDA(4'h1): T0 MEM_RD, EN_MD, MD_SEL=0 (wait-capable); T1 EN_AC, AC_SEL=0.
  - STA(4'h2): T0 EN_MD, MD_SEL=1; T1 WRITE (wait-capable, EN_* low).
  - ADD(4'h3): T0 as LDA T0; T1 EN_AC, AC_SEL=1.
  - JMP(4'h4): T0 EN_PC, PC_SEL=1.
  - HALT_OPCODE: T0 moves to HALT.
  - Any other opcode: NOP, T0 only, no enables.
- HALT:
  - HALTED=1, FETCH=EXECUTE=0, T=0000, all enables 0.
  - RUN=1 moves to FETCH/T0 next cycle.
  - RUN is ignored in all other states.
- IR_OUT is sampled only in EXECUTE; changes during FETCH have no effect.
- Reset mid-stall or mid-WRITE: outputs drop immediately (async); restart at FETCH/T0.
- Invariants:
  - FETCH and EXECUTE are never both high.
  - T is always one-hot outside HALT.
  - At most one of MEM_RD/WRITE is high.

Decomposition:
- Shared package dunc16_pkg:
  - opcode constants OP_LDA, OP_STA, OP_ADD, OP_JMP, OP_HLT;
  - phase enum;
  - mux-select constants (SEL_PC, SEL_MD, SEL_MEM, SEL_AC, SEL_ALU, SEL_INC).
- One sub-module dunc16_timing: step counter plus stall/clear logic, outputs one-hot T.

Test Plan:
- Reset release, MEM_READY=1, IR=4'h0:
  - FETCH/T0..T3 in cycles 1–4, EN_PC=1 exactly in cycle 2, EXECUTE/T0 in cycle 5, FETCH/T0 in cycle 6.
- IR=OP_LDA, MEM_READY held low 3 cycles in EXECUTE/T0:
  - T=0001 with MEM_RD=1 for 4 cycles, EN_MD=1 only in the 4th;
  - next cycle EN_AC=1, AC_SEL=0.
- IR=OP_STA:
  - EXECUTE/T0 EN_MD=1, MD_SEL=1;
  - T1 WRITE=1 until MEM_READY;
  - no EN_* during WRITE; MEM_RD=0 throughout.
- IR=OP_JMP then OP_ADD:
  - JMP: EN_PC=1, PC_SEL=1 in EXECUTE/T0, total instruction 5 cycles;
  - ADD: EXECUTE/T1 EN_AC=1, AC_SEL=1.
- IR=4'hF:
  - HALTED=1, T=0000 indefinitely;
  - RUN pulse during FETCH earlier ignored; RUN in HALT gives FETCH/T0 next cycle.
- RESET_N low mid fetch T1 stall:
  - enables and MEM_RD drop the same cycle;
  - after release, FETCH/T0 with HALTED=0.
